machine_timer: RTL and testbench

- Memory-mapped machine timer and software-interrupt unit (CLINT-style) for the single-hart core.
- Owns the 64-bit mtime and mtimecmp registers and the msip bit.
- Drives the pending inputs consumed by the CSR file: mtip = (mtime >= mtimecmp), and msip.
- Sits on the core's data bus behind the address decoder in top.

---
 rtl/machine_timer.sv | 127 ++++++++++++
 tb/tb_machine_timer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/machine_timer.sv
// Machine timer and software-interrupt unit: 64-bit mtime/mtimecmp, msip and the
// mtip/msip pending lines for the CSR file, on a simple valid/ready data bus.
module machine_timer #(
  parameter int unsigned PRESCALE       = 1,
  parameter logic [63:0] RESET_MTIMECMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        bus_valid,
  input  logic        bus_write,
  input  logic [2:0]  bus_address,
  input  logic [31:0] bus_write_value,
  input  logic [3:0]  bus_write_strobe,
  output logic [31:0] bus_read_value,
  output logic        bus_ready,
  output logic [63:0] mtime,
  output logic        mtip,
  output logic        msip
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  localparam logic [2:0] ADDR_MSIP   = 3'd0;
  localparam logic [2:0] ADDR_CMP_LO = 3'd1;
  localparam logic [2:0] ADDR_CMP_HI = 3'd2;
  localparam logic [2:0] ADDR_MT_LO  = 3'd3;
  localparam logic [2:0] ADDR_MT_HI  = 3'd4;

  logic [PS_W-1:0] ps_count;
  logic [63:0]     mtimecmp;
  logic            tick_c;
  logic            accept_c;
  logic            wr_msip_c, wr_cmp_lo_c, wr_cmp_hi_c, wr_mt_lo_c, wr_mt_hi_c;
  logic [31:0]     read_mux_c;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  assign tick_c   = (ps_count == PS_MAX);
  assign accept_c = bus_valid && !bus_ready;

  // Write decode and read mux; both look at the registers before this edge.
  always_comb begin
    wr_msip_c   = 1'b0;
    wr_cmp_lo_c = 1'b0;
    wr_cmp_hi_c = 1'b0;
    wr_mt_lo_c  = 1'b0;
    wr_mt_hi_c  = 1'b0;
    read_mux_c  = 32'd0;
    case (bus_address)
      ADDR_MSIP: begin
        wr_msip_c  = accept_c && bus_write && bus_write_strobe[0];
        read_mux_c = {31'd0, msip};
      end
      ADDR_CMP_LO: begin
        wr_cmp_lo_c = accept_c && bus_write;
        read_mux_c  = mtimecmp[31:0];
      end
      ADDR_CMP_HI: begin
        wr_cmp_hi_c = accept_c && bus_write;
        read_mux_c  = mtimecmp[63:32];
      end
      ADDR_MT_LO: begin
        wr_mt_lo_c = accept_c && bus_write;
        read_mux_c = mtime[31:0];
      end
      ADDR_MT_HI: begin
        wr_mt_hi_c = accept_c && bus_write;
        read_mux_c = mtime[63:32];
      end
      default: read_mux_c = 32'd0;
    endcase
  end

  // Free-running prescaler.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ps_count <= '0;
    else if (tick_c) ps_count <= '0;
    else ps_count <= ps_count + PS_W'(1);
  end

  // A software write to either half of mtime wins over the increment for the whole register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mtime <= 64'd0;
    end else if (wr_mt_lo_c || wr_mt_hi_c) begin
      if (wr_mt_lo_c) mtime[31:0]  <= merge_bytes(mtime[31:0], bus_write_value, bus_write_strobe);
      if (wr_mt_hi_c) mtime[63:32] <= merge_bytes(mtime[63:32], bus_write_value, bus_write_strobe);
    end else if (tick_c) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mtimecmp <= RESET_MTIMECMP;
      msip     <= 1'b0;
    end else begin
      if (wr_cmp_lo_c) mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], bus_write_value, bus_write_strobe);
      if (wr_cmp_hi_c) mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], bus_write_value, bus_write_strobe);
      if (wr_msip_c)   msip            <= bus_write_value[0];
    end
  end

  // One-cycle completion pulse; read data is zero for writes and idle cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus_ready      <= 1'b0;
      bus_read_value <= 32'd0;
    end else begin
      bus_ready      <= accept_c;
      bus_read_value <= (accept_c && !bus_write) ? read_mux_c : 32'd0;
    end
  end

  assign mtip = (mtime >= mtimecmp);

endmodule

// File: tb/tb_machine_timer.sv
// Directed bench for machine_timer: one instance at PRESCALE=1 on the bus, one at PRESCALE=4.
module tb_machine_timer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        bus_valid, bus_write;
  logic [2:0]  bus_address;
  logic [31:0] bus_write_value;
  logic [3:0]  bus_write_strobe;
  logic [31:0] bus_read_value;
  logic        bus_ready;
  logic [63:0] mtime;
  logic        mtip, msip;

  logic        b4_valid, b4_write;
  logic [2:0]  b4_address;
  logic [31:0] b4_write_value;
  logic [3:0]  b4_write_strobe;
  logic [31:0] b4_read_value;
  logic        b4_ready;
  logic [63:0] mtime4;
  logic        mtip4, msip4;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clock = ~clock;

  machine_timer #(.PRESCALE(1)) dut (
    .clock(clock), .reset_n(reset_n),
    .bus_valid(bus_valid), .bus_write(bus_write), .bus_address(bus_address),
    .bus_write_value(bus_write_value), .bus_write_strobe(bus_write_strobe),
    .bus_read_value(bus_read_value), .bus_ready(bus_ready),
    .mtime(mtime), .mtip(mtip), .msip(msip)
  );

  machine_timer #(.PRESCALE(4)) dut4 (
    .clock(clock), .reset_n(reset_n),
    .bus_valid(b4_valid), .bus_write(b4_write), .bus_address(b4_address),
    .bus_write_value(b4_write_value), .bus_write_strobe(b4_write_strobe),
    .bus_read_value(b4_read_value), .bus_ready(b4_ready),
    .mtime(mtime4), .mtip(mtip4), .msip(msip4)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Called just after a clock edge with bus_ready low; returns just after the idle cycle.
  task automatic bus_op(input logic wr, input logic [2:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output logic [31:0] rdata,
                        output logic mtip_a, output logic msip_a);
    bus_valid        = 1'b1;
    bus_write        = wr;
    bus_address      = addr;
    bus_write_value  = wdata;
    bus_write_strobe = strb;
    @(posedge clock); #1;
    check_eq("ready_pulse", 64'(bus_ready), 64'd1);
    rdata  = bus_read_value;
    mtip_a = mtip;
    msip_a = msip;
    if (wr) check_eq("write_rdata_zero", 64'(bus_read_value), 64'd0);
    bus_valid = 1'b0;
    @(posedge clock); #1;
    check_eq("ready_one_cycle", 64'(bus_ready), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rv;
    logic        ma, sa;

    reset_n = 1'b0;
    bus_valid = 1'b0; bus_write = 1'b0; bus_address = 3'd0;
    bus_write_value = 32'd0; bus_write_strobe = 4'd0;
    b4_valid = 1'b0; b4_write = 1'b0; b4_address = 3'd0;
    b4_write_value = 32'd0; b4_write_strobe = 4'd0;

    #12;
    check_eq("rst_mtime", mtime, 64'd0);
    check_eq("rst_mtip", 64'(mtip), 64'd0);
    check_eq("rst_msip", 64'(msip), 64'd0);
    check_eq("rst_ready", 64'(bus_ready), 64'd0);
    check_eq("rst_rdata", 64'(bus_read_value), 64'd0);
    check_eq("rst_mtime4", mtime4, 64'd0);

    @(negedge clock);
    reset_n = 1'b1;
    check_eq("release_mtime", mtime, 64'd0);
    for (int n = 1; n <= 8; n++) begin
      @(posedge clock); #1;
      if (n <= 2) check_eq("count_mtime", mtime, 64'(n));
      check_eq("ps4_mtime", mtime4, 64'(n / 4));
    end

    // PRESCALE=4: ticks on edges 4, 8, 12; write lands on edge 12.
    repeat (3) begin @(posedge clock); #1; end
    b4_valid = 1'b1; b4_write = 1'b1; b4_address = 3'd3;
    b4_write_value = 32'h100; b4_write_strobe = 4'hF;
    @(posedge clock); #1;
    check_eq("ps4_ready", 64'(b4_ready), 64'd1);
    check_eq("ps4_wr_on_tick", mtime4, 64'h100);
    b4_valid = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    check_eq("ps4_hold", mtime4, 64'h100);
    @(posedge clock); #1;
    check_eq("ps4_next_tick", mtime4, 64'h101);

    // mtimecmp = 5, then restart mtime at 0 and watch mtip rise at 5.
    bus_op(1'b1, 3'd1, 32'd5, 4'hF, rv, ma, sa);
    check_eq("cmp_lo_only_mtip", 64'(mtip), 64'd0);
    bus_op(1'b1, 3'd2, 32'd0, 4'hF, rv, ma, sa);
    check_eq("cmp_hi_mtip_on", 64'(ma), 64'd1);
    bus_op(1'b1, 3'd3, 32'd0, 4'hF, rv, ma, sa);
    check_eq("mtime_zero_mtip", 64'(ma), 64'd0);
    for (int k = 1; k <= 7; k++) begin
      check_eq("run_mtime", mtime, 64'(k));
      check_eq("run_mtip", 64'(mtip), 64'(k >= 5));
      @(posedge clock); #1;
    end
    bus_op(1'b1, 3'd1, 32'hFFFF_FFFF, 4'hF, rv, ma, sa);
    check_eq("cmp_raise_mtip_off", 64'(ma), 64'd0);

    // 64-bit wrap and low-to-high carry.
    bus_op(1'b1, 3'd4, 32'hFFFF_FFFF, 4'hF, rv, ma, sa);
    bus_op(1'b1, 3'd3, 32'hFFFF_FFFE, 4'hF, rv, ma, sa);
    check_eq("all_ones", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clock); #1;
    check_eq("wrap_zero", mtime, 64'd0);
    check_eq("wrap_mtip", 64'(mtip), 64'd0);
    bus_op(1'b1, 3'd4, 32'd0, 4'hF, rv, ma, sa);
    bus_op(1'b1, 3'd3, 32'hFFFF_FFFF, 4'hF, rv, ma, sa);
    check_eq("carry", mtime, 64'h0000_0001_0000_0000);
    check_eq("carry_mtip", 64'(mtip), 64'd1);
    bus_op(1'b0, 3'd3, 32'd0, 4'h0, rv, ma, sa);
    check_eq("read_mtime_lo", 64'(rv), 64'd0);
    bus_op(1'b0, 3'd4, 32'd0, 4'h0, rv, ma, sa);
    check_eq("read_mtime_hi", 64'(rv), 64'd1);

    // Byte strobes, unmapped addresses.
    bus_op(1'b1, 3'd1, 32'h1122_3344, 4'hF, rv, ma, sa);
    bus_op(1'b1, 3'd1, 32'hAABB_CCDD, 4'b0101, rv, ma, sa);
    bus_op(1'b0, 3'd1, 32'd0, 4'h0, rv, ma, sa);
    check_eq("strobe_merge", 64'(rv), 64'h11BB_33DD);
    bus_op(1'b0, 3'd2, 32'd0, 4'h0, rv, ma, sa);
    check_eq("read_cmp_hi", 64'(rv), 64'd0);
    bus_op(1'b0, 3'd6, 32'd0, 4'h0, rv, ma, sa);
    check_eq("read_unmapped", 64'(rv), 64'd0);
    bus_op(1'b1, 3'd7, 32'hFFFF_FFFF, 4'hF, rv, ma, sa);
    bus_op(1'b0, 3'd1, 32'd0, 4'h0, rv, ma, sa);
    check_eq("unmapped_wr_ignored", 64'(rv), 64'h11BB_33DD);

    // msip: only bit 0 under strobe[0].
    bus_op(1'b1, 3'd0, 32'd1, 4'b0001, rv, ma, sa);
    check_eq("msip_set", 64'(sa), 64'd1);
    bus_op(1'b1, 3'd0, 32'd0, 4'b1110, rv, ma, sa);
    check_eq("msip_no_strobe", 64'(sa), 64'd1);
    bus_op(1'b0, 3'd0, 32'd0, 4'h0, rv, ma, sa);
    check_eq("msip_read", 64'(rv), 64'd1);
    bus_op(1'b1, 3'd0, 32'hFFFF_FFFE, 4'b0001, rv, ma, sa);
    check_eq("msip_clear", 64'(sa), 64'd0);

    // Reset with a read presented but not yet completed.
    bus_valid = 1'b1; bus_write = 1'b0; bus_address = 3'd3;
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("midrst_mtime", mtime, 64'd0);
    check_eq("midrst_ready", 64'(bus_ready), 64'd0);
    check_eq("midrst_mtip", 64'(mtip), 64'd0);
    repeat (3) begin
      @(posedge clock); #1;
      check_eq("midrst_no_ready", 64'(bus_ready), 64'd0);
    end
    bus_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check_eq("post_rst_ready", 64'(bus_ready), 64'd0);
    check_eq("post_rst_mtime", mtime, 64'd1);
    bus_op(1'b0, 3'd3, 32'd0, 4'h0, rv, ma, sa);
    check_eq("reissued_read", 64'(rv), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
